// File: rtl/moving_window_integrator_pkg.sv
// Shared constants and types for the QRS moving-window integrator and its neighbours.
// MWI_LOG2_WIN is also read by the peak detector threshold logic.
package moving_window_integrator_pkg;

   localparam int NBIT         = 16;
   localparam int MWI_LOG2_WIN = 5;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } mwi_state_t;

endpackage

// File: rtl/moving_window_integrator_sample_delay_line.sv
// Circular WIN x NBIT sample store: registered write, combinational read of the
// entry currently at addr (the value before this edge's write lands).
module sample_delay_line #(
   parameter int NBIT     = 16,
   parameter int LOG2_WIN = 5
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [LOG2_WIN-1:0] addr,
   input  logic [NBIT-1:0]     wr_data,
   output logic [NBIT-1:0]     rd_data
);

   localparam int WIN = 2 ** LOG2_WIN;

   // Storage carries no reset; the top never consumes an entry it has not written.
   logic [NBIT-1:0] mem_reg [WIN];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[addr] <= wr_data;
      end
   end

   assign rd_data = mem_reg[addr];

endmodule

// File: rtl/moving_window_integrator.sv
// Moving-window integrator: running mean of the last 2**LOG2_WIN accepted samples,
// with valid handshake, window-full indicator and synchronous clear.
module moving_window_integrator
   import moving_window_integrator_pkg::*;
#(
   parameter int NBIT     = moving_window_integrator_pkg::NBIT,
   parameter int LOG2_WIN = moving_window_integrator_pkg::MWI_LOG2_WIN
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   din_valid,
   input  logic signed [NBIT-1:0] din,
   output logic signed [NBIT-1:0] dout,
   output logic                   dout_valid,
   output logic                   primed
);

   localparam int ACCW = NBIT + LOG2_WIN;
   localparam logic [LOG2_WIN-1:0] LAST_IDX = '1;

   mwi_state_t                state_reg, state_next;
   logic [LOG2_WIN-1:0]       fill_cnt_reg, fill_cnt_next;
   logic [LOG2_WIN-1:0]       wr_ptr_reg, wr_ptr_next;
   logic signed [ACCW-1:0]    sum_reg, sum_next;
   logic signed [NBIT-1:0]    dout_reg, dout_next;
   logic                      dout_valid_reg, dout_valid_next;
   logic                      primed_reg, primed_next;

   logic                      accept;
   logic [NBIT-1:0]           old_sample;
   logic signed [ACCW-1:0]    din_ext, old_ext;

   assign accept = din_valid & ~clear;

   sample_delay_line #(
      .NBIT     (NBIT),
      .LOG2_WIN (LOG2_WIN)
   ) u_delay_line (
      .clk     (clk),
      .wr_en   (accept),
      .addr    (wr_ptr_reg),
      .wr_data (din),
      .rd_data (old_sample)
   );

   // While filling, the slot being overwritten has never held a real sample.
   assign din_ext = {{LOG2_WIN{din[NBIT-1]}}, din};
   assign old_ext = (state_reg == ST_RUN) ? {{LOG2_WIN{old_sample[NBIT-1]}}, old_sample}
                                          : '0;

   always_comb begin
      state_next      = state_reg;
      fill_cnt_next   = fill_cnt_reg;
      wr_ptr_next     = wr_ptr_reg;
      sum_next        = sum_reg;
      dout_next       = dout_reg;
      dout_valid_next = 1'b0;
      primed_next     = primed_reg;

      if (clear) begin
         state_next    = ST_FILL;
         fill_cnt_next = '0;
         wr_ptr_next   = '0;
         sum_next      = '0;
         dout_next     = '0;
         primed_next   = 1'b0;
      end else if (din_valid) begin
         sum_next        = sum_reg + din_ext - old_ext;
         wr_ptr_next     = wr_ptr_reg + 1'b1;
         // Upper NBIT bits of the accumulator are exactly sum >>> LOG2_WIN.
         dout_next       = sum_next[ACCW-1:LOG2_WIN];
         dout_valid_next = 1'b1;
         if (state_reg == ST_FILL) begin
            fill_cnt_next = fill_cnt_reg + 1'b1;
            if (fill_cnt_reg == LAST_IDX) begin
               state_next  = ST_RUN;
               primed_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_FILL;
         fill_cnt_reg   <= '0;
         wr_ptr_reg     <= '0;
         sum_reg        <= '0;
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
         primed_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         fill_cnt_reg   <= fill_cnt_next;
         wr_ptr_reg     <= wr_ptr_next;
         sum_reg        <= sum_next;
         dout_reg       <= dout_next;
         dout_valid_reg <= dout_valid_next;
         primed_reg     <= primed_next;
      end
   end

   assign dout       = dout_reg;
   assign dout_valid = dout_valid_reg;
   assign primed     = primed_reg;

endmodule
